arduino_word_tx: RTL and testbench

//  Processor-to-Arduino transmitter. Takes one DATA_LENGTH-bit word from the core.

---
 rtl/arduino_word_tx.sv | 141 ++++++++++++++
 tb/tb_arduino_word_tx.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arduino_word_tx.sv
// Processor-to-Arduino word transmitter: sends one DATA_LENGTH-bit word LSB-first as
// byte transfers over an 8-bit port, each byte using a 4-phase strobe/ack handshake.
module arduino_word_tx #(
    parameter int BYTE_LENGTH    = 8,
    parameter int DATA_LENGTH    = 32,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flag_write_arduino,
    input  logic [DATA_LENGTH-1:0] module_input,
    output logic                   busy,
    output logic                   done,
    output logic                   timeout_error,
    output logic [BYTE_LENGTH-1:0] system_output,
    output logic                   system_strobe,
    input  logic                   system_ack
);

    localparam int BYTES_PER_WORD = DATA_LENGTH / BYTE_LENGTH;
    localparam int CNT_W          = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam int TMR_W          = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(BYTES_PER_WORD - 1);
    localparam logic [TMR_W-1:0] TIMER_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETUP, WAIT_ACK, WAIT_REL} state_t;

    state_t                 state, state_next;
    logic [DATA_LENGTH-1:0] word, word_next, word_shift;
    logic [CNT_W-1:0]       idx, idx_next;
    logic [TMR_W-1:0]       timer, timer_next;
    logic [BYTE_LENGTH-1:0] out_next;
    logic                   strobe_next, busy_next, done_next, terr_next;
    logic                   ack_meta, ack_s;

    // The Arduino acknowledge is asynchronous to our clock.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ack_meta <= 1'b0;
            ack_s    <= 1'b0;
        end else begin
            ack_meta <= system_ack;
            ack_s    <= ack_meta;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            word          <= '0;
            idx           <= '0;
            timer         <= '0;
            system_output <= '0;
            system_strobe <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            timeout_error <= 1'b0;
        end else begin
            state         <= state_next;
            word          <= word_next;
            idx           <= idx_next;
            timer         <= timer_next;
            system_output <= out_next;
            system_strobe <= strobe_next;
            busy          <= busy_next;
            done          <= done_next;
            timeout_error <= terr_next;
        end
    end

    // Remaining bytes are shifted down so the next byte always sits in the low lane.
    assign word_shift = word >> BYTE_LENGTH;

    always_comb begin
        state_next  = state;
        word_next   = word;
        idx_next    = idx;
        timer_next  = timer;
        out_next    = system_output;
        strobe_next = system_strobe;
        busy_next   = busy;
        done_next   = 1'b0;
        terr_next   = timeout_error;

        case (state)
            IDLE: begin
                if (flag_write_arduino) begin
                    word_next  = module_input;
                    idx_next   = '0;
                    terr_next  = 1'b0;
                    out_next   = module_input[BYTE_LENGTH-1:0];
                    busy_next  = 1'b1;
                    state_next = SETUP;
                end
            end
            SETUP: begin
                if (!ack_s) begin
                    strobe_next = 1'b1;
                    state_next  = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (ack_s) begin
                    strobe_next = 1'b0;
                    state_next  = WAIT_REL;
                end
            end
            WAIT_REL: begin
                if (!ack_s) begin
                    if (idx == LAST_IDX) begin
                        done_next  = 1'b1;
                        busy_next  = 1'b0;
                        state_next = IDLE;
                    end else begin
                        idx_next   = idx + CNT_W'(1);
                        word_next  = word_shift;
                        out_next   = word_shift[BYTE_LENGTH-1:0];
                        state_next = SETUP;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // A legitimate handshake step in the final cycle wins over the timeout.
        if (state_next != state) begin
            timer_next = '0;
        end else if (state != IDLE) begin
            if (timer == TIMER_LAST) begin
                strobe_next = 1'b0;
                terr_next   = 1'b1;
                busy_next   = 1'b0;
                state_next  = IDLE;
                timer_next  = '0;
            end else begin
                timer_next = timer + TMR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_arduino_word_tx.sv
// Self-checking bench for arduino_word_tx: responder model, byte scoreboard,
// per-cycle protocol/busy/timeout model and directed plus randomized transfers.
module tb_arduino_word_tx;

    localparam int T  = 16;
    localparam int BL = 8;
    localparam int DL = 32;
    localparam int NB = DL / BL;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          flag_write_arduino = 1'b0;
    logic [DL-1:0] module_input = '0;
    logic          busy, done, timeout_error, system_strobe;
    logic [BL-1:0] system_output;
    logic          system_ack = 1'b0;

    arduino_word_tx #(.BYTE_LENGTH(BL), .DATA_LENGTH(DL), .TIMEOUT_CYCLES(T)) dut (
        .clock(clock),
        .reset(reset),
        .flag_write_arduino(flag_write_arduino),
        .module_input(module_input),
        .busy(busy),
        .done(done),
        .timeout_error(timeout_error),
        .system_output(system_output),
        .system_strobe(system_strobe),
        .system_ack(system_ack)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Responder controls and model state.
    int       ack_delay = 1, rel_delay = 1, wcnt = 0;
    bit       never_ack = 0, ack_force = 0;
    bit       req_flag = 0;
    logic [DL-1:0] req_word = '0;
    logic [BL-1:0] exp_q[$];
    logic [BL-1:0] sent_log[$];
    bit       model_busy = 0, model_timeout = 0;
    bit       prev_strobe = 0, track_to = 0;
    logic [BL-1:0] prev_out = '0;
    int       sc = 0, done_count = 0;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Arduino side: ack some cycles after strobe rises, release some cycles after it falls.
    always @(negedge clock) begin
        if (ack_force) begin
            system_ack = 1'b1;
            wcnt = 0;
        end else if (never_ack) begin
            system_ack = 1'b0;
            wcnt = 0;
        end else if (!system_ack) begin
            if (system_strobe) begin
                if (wcnt >= ack_delay) begin system_ack = 1'b1; wcnt = 0; end
                else wcnt++;
            end else wcnt = 0;
        end else begin
            if (!system_strobe) begin
                if (wcnt >= rel_delay) begin system_ack = 1'b0; wcnt = 0; end
                else wcnt++;
            end else wcnt = 0;
        end
    end

    // Reference model and per-cycle comparison.
    always @(negedge clock) begin
        if (reset) begin
            exp_q.delete();
            model_busy = 0; model_timeout = 0;
            prev_strobe = 0; prev_out = '0;
            track_to = 0; sc = 0; req_flag = 0;
        end else begin
            if (req_flag) begin
                req_flag = 0;
                if (!model_busy) begin
                    for (int k = 0; k < NB; k++) exp_q.push_back(req_word[k*BL +: BL]);
                    model_busy = 1;
                    model_timeout = 0;
                end
            end
            if (prev_strobe && system_strobe)
                check_output("stable_byte", 32'(system_output), 32'(prev_out));
            if (!prev_strobe && system_strobe) begin
                if (exp_q.size() == 0) check_output("unexpected_strobe", 1, 0);
                else begin
                    logic [BL-1:0] b;
                    b = exp_q.pop_front();
                    check_output("byte", 32'(system_output), 32'(b));
                    sent_log.push_back(system_output);
                end
                if (never_ack) begin track_to = 1; sc = 0; end
            end else if (track_to) begin
                sc++;
                if (sc < T) check_output("strobe_held", 32'(system_strobe), 1);
                else begin
                    check_output("timeout_drop", 32'(system_strobe), 0);
                    track_to = 0;
                    model_busy = 0;
                    model_timeout = 1;
                    exp_q.delete();
                end
            end
            if (done) begin
                check_output("done_legal", 32'(model_busy && exp_q.size() == 0 && !system_strobe), 1);
                model_busy = 0;
                done_count++;
            end
            check_output("busy", 32'(busy), 32'(model_busy));
            check_output("timeout_flag", 32'(timeout_error), 32'(model_timeout));
            prev_strobe = system_strobe;
            prev_out = system_output;
        end
    end

    task automatic drive_request(input logic [DL-1:0] w);
        flag_write_arduino = 1'b1;
        module_input = w;
        req_word = w;
        req_flag = 1;
        @(posedge clock);
        #1 flag_write_arduino = 1'b0;
    endtask

    task automatic apply_stimulus(input logic [DL-1:0] w);
        @(negedge clock);
        #1 drive_request(w);
    endtask

    task automatic wait_done(input int max_cycles);
        int n = 0;
        bit got = 0;
        while (n < max_cycles && !got) begin
            @(negedge clock);
            #2 if (done) got = 1;
            n++;
        end
        check_output("done_seen", 32'(got), 1);
    endtask

    task automatic check_log(input string name, input logic [DL-1:0] w);
        check_output({name, "_count"}, 32'(sent_log.size()), NB);
        for (int k = 0; k < NB && k < sent_log.size(); k++)
            check_output(name, 32'(sent_log[k]), 32'(w[k*BL +: BL]));
    endtask

    initial begin
        int d0;
        bit chain;
        logic [DL-1:0] w;
        logic [31:0] lit;

        #1;
        check_output("rst_strobe", 32'(system_strobe), 0);
        check_output("rst_busy", 32'(busy), 0);
        check_output("rst_output", 32'(system_output), 0);
        repeat (3) @(posedge clock);
        #3 reset = 1'b0;

        // Word 0xA1B2C3D4, ack 3 cycles after strobe, release 2 later.
        ack_delay = 3; rel_delay = 2;
        sent_log.delete();
        d0 = done_count;
        apply_stimulus(32'hA1B2C3D4);
        wait_done(300);
        repeat (3) @(negedge clock);
        #2;
        lit = 32'h000000D4; check_output("t2_byte0", 32'(sent_log.size() > 0 ? sent_log[0] : 8'h00), lit);
        lit = 32'h000000A1; check_output("t2_byte3", 32'(sent_log.size() > 3 ? sent_log[3] : 8'h00), lit);
        check_log("t2_bytes", 32'hA1B2C3D4);
        check_output("t2_done_once", 32'(done_count - d0), 1);
        check_output("t2_busy_after", 32'(busy), 0);
        check_output("t2_last_byte_kept", 32'(system_output), 32'hA1);

        // A request while busy is ignored.
        ack_delay = 1; rel_delay = 1;
        sent_log.delete();
        d0 = done_count;
        apply_stimulus(32'h55AA55AA);
        repeat (4) @(negedge clock);
        apply_stimulus(32'h11111111);
        wait_done(300);
        repeat (4) @(negedge clock);
        #2;
        check_log("t3_bytes", 32'h55AA55AA);
        check_output("t3_done_once", 32'(done_count - d0), 1);

        // Back-to-back request in the done cycle.
        sent_log.delete();
        apply_stimulus(32'hDEADBEEF);
        wait_done(300);
        drive_request(32'h00000001);
        sent_log.delete();
        wait_done(300);
        #1;
        lit = 32'h00000001; check_output("t6_byte0", 32'(sent_log.size() > 0 ? sent_log[0] : 8'hFF), lit);
        check_log("t6_bytes", 32'h00000001);

        // Ack held high after the last byte: SETUP must wait for release.
        @(negedge clock);
        #2 ack_force = 1;
        repeat (4) @(negedge clock);
        rel_delay = 0;
        sent_log.delete();
        apply_stimulus(32'h0F1E2D3C);
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            #2 check_output("t5_strobe_low", 32'(system_strobe), 0);
        end
        ack_force = 0;
        wait_done(300);
        #1 check_log("t5_bytes", 32'h0F1E2D3C);

        // Responder never acks: timeout, then a new request clears the flag.
        never_ack = 1;
        d0 = done_count;
        apply_stimulus(32'h12345678);
        begin
            int n = 0;
            @(negedge clock);
            while (n < 80 && busy) begin @(negedge clock); n++; end
            #2 check_output("t4_busy_dropped", 32'(busy), 0);
        end
        check_output("t4_timeout_set", 32'(timeout_error), 1);
        check_output("t4_no_done", 32'(done_count - d0), 0);
        never_ack = 0;
        apply_stimulus(32'h9ABCDEF0);
        @(negedge clock);
        #2 check_output("t4_timeout_cleared", 32'(timeout_error), 0);
        wait_done(300);

        // Reset asserted while waiting for ack.
        never_ack = 1;
        apply_stimulus(32'hCAFEF00D);
        begin
            int n = 0;
            while (n < 20 && !system_strobe) begin @(negedge clock); n++; end
            check_output("t1_strobe_seen", 32'(system_strobe), 1);
        end
        @(posedge clock);
        #3 reset = 1'b1;
        #1;
        check_output("t1_strobe", 32'(system_strobe), 0);
        check_output("t1_busy", 32'(busy), 0);
        check_output("t1_done", 32'(done), 0);
        check_output("t1_output", 32'(system_output), 0);
        never_ack = 0;
        repeat (2) @(posedge clock);
        #3 reset = 1'b0;
        repeat (3) @(negedge clock);
        #2 check_output("t1_idle_busy", 32'(busy), 0);

        // Randomized words, delays, ignored requests and chained requests.
        chain = 0;
        for (int i = 0; i < 12; i++) begin
            w = $urandom;
            ack_delay = $urandom_range(0, 4);
            rel_delay = $urandom_range(0, 4);
            sent_log.delete();
            if (chain) drive_request(w);
            else apply_stimulus(w);
            if (i % 3 == 0) begin
                repeat (3) @(negedge clock);
                apply_stimulus($urandom);
            end
            wait_done(400);
            #1 check_log("rand_bytes", w);
            chain = 1'($urandom_range(0, 1));
        end

        repeat (5) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
